// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word, line and mask types plus cache constants
// Contents:
//   lc3b_word        16-bit CPU word / byte address
//   lc3b_cacheline   128-bit cache line (eight words)
//   lc3b_mem_wmask   2-bit byte-lane write mask
//   LC3B_OFFSET_BITS byte-offset width inside a line
//   LC3B_LINE_WORDS  words per line
//   cache_state_e    controller states
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [1:0]   lc3b_mem_wmask;

  localparam int LC3B_OFFSET_BITS = 4;
  localparam int LC3B_LINE_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_e;

endpackage

// File: rtl/l1_cache_nway_if.sv
// rtl/l1_cache_nway_if.sv - CPU-side and next-level bus bundle for the L1 cache
// Signals:
//   mem_read/mem_write, mem_address, mem_wdata, mem_byte_enable  CPU request
//   mem_resp, mem_rdata                                          CPU response
//   l2_read/l2_write, l2_address, l2_wdata, eviction             next-level request
//   l2_resp, l2_rdata                                            next-level response
// Modports:
//   master  CPU + next-level memory side (drives requests and l2 responses)
//   slave   the cache itself
interface l1_cache_nway_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  logic          mem_resp;
  lc3b_word      mem_rdata;

  logic          l2_read;
  logic          l2_write;
  lc3b_word      l2_address;
  lc3b_cacheline l2_wdata;
  logic          l2_resp;
  lc3b_cacheline l2_rdata;
  logic          eviction;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output l2_resp, l2_rdata,
    input  mem_resp, mem_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata, eviction
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  l2_resp, l2_rdata,
    output mem_resp, mem_rdata,
    output l2_read, l2_write, l2_address, l2_wdata, eviction
  );

endinterface

// File: rtl/l1_cache_nway_plru.sv
// rtl/l1_cache_nway_plru.sv - tree pseudo-LRU update and victim encoder (module plru_tree)
// Ports:
//   bits_i       current WAYS-1 tree bits of one set (bit k-1 holds heap node k)
//   hit_way_i    way being touched
//   next_bits_o  tree bits after touching hit_way_i
//   victim_o     way the current tree points at
// A node bit of 0 points toward the lower half, 1 toward the upper half.
module plru_tree #(
  parameter int WAYS = 2,
  localparam int LW = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits_i,
  input  logic [LW-1:0]   hit_way_i,
  output logic [WAYS-2:0] next_bits_o,
  output logic [LW-1:0]   victim_o
);

  // Heap-indexed view: node 1 is the root, children of n are 2n and 2n+1.
  logic [WAYS-1:1] tree;
  logic [WAYS-1:1] next_tree;
  logic [LW-1:0]   hnode;
  logic [LW-1:0]   vnode;

  always_comb begin
    tree      = bits_i;
    next_tree = tree;
    victim_o  = '0;
    hnode     = LW'(1);
    vnode     = LW'(1);
    for (int lvl = 0; lvl < LW; lvl++) begin
      // Touch: every node on the path points to the sibling subtree.
      next_tree[hnode] = ~hit_way_i[LW-1-lvl];
      hnode            = LW'({hnode, hit_way_i[LW-1-lvl]});
      // Victim: follow the pointers from the root.
      victim_o[LW-1-lvl] = tree[vnode];
      vnode              = LW'({vnode, tree[vnode]});
    end
    next_bits_o = next_tree;
  end

endmodule

// File: rtl/l1_cache_nway.sv
// rtl/l1_cache_nway.sv - N-way set-associative write-back L1 cache with tree-PLRU replacement
// Parameters: WAYS (2..8, power of two), SETS (2..64, power of two)
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset (clears valid, dirty, PLRU, FSM)
//   bus  l1_cache_nway_if.slave: CPU request/response and next-level traffic
module l1_cache_nway
  import lc3b_types::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input logic            clk,
  input logic            rst,
  l1_cache_nway_if.slave bus
);

  localparam int LW     = $clog2(WAYS);
  localparam int IW     = $clog2(SETS);
  localparam int TW     = 16 - LC3B_OFFSET_BITS - IW;
  localparam int WORD_W = 128 / LC3B_LINE_WORDS;

  // Address split
  logic [IW-1:0] idx;
  logic [TW-1:0] tag_in;
  logic [2:0]    word_sel;
  logic [6:0]    word_lsb;

  assign idx      = bus.mem_address[LC3B_OFFSET_BITS +: IW];
  assign tag_in   = bus.mem_address[15 -: TW];
  assign word_sel = bus.mem_address[3:1];
  assign word_lsb = {word_sel, 4'h0};

  // Storage: status bits are reset, tag/data arrays are not.
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-2:0] plru_q  [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  lc3b_cacheline   data_q  [SETS][WAYS];

  cache_state_e  state_q, state_d;
  logic [LW-1:0] victim_q, victim_d;

  logic req;
  assign req = bus.mem_read | bus.mem_write;

  // Lookup
  logic [WAYS-1:0] match;
  logic [LW-1:0]   hit_way;
  logic            hit_one;

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag_in);
      if (match[w]) hit_way = LW'(w);
    end
  end

  // A hit needs exactly one matching way; a multi-match is treated as a miss.
  assign hit_one = (match != '0) && ((match & (match - WAYS'(1))) == '0);

  // Victim choice: lowest invalid way first, otherwise the PLRU pointer.
  logic [LW-1:0]   plru_victim;
  logic [LW-1:0]   victim_sel;
  logic [WAYS-2:0] plru_next;
  logic            found_invalid;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i      (plru_q[idx]),
    .hit_way_i   (hit_way),
    .next_bits_o (plru_next),
    .victim_o    (plru_victim)
  );

  always_comb begin
    victim_sel    = plru_victim;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[idx][w] && !found_invalid) begin
        victim_sel    = LW'(w);
        found_invalid = 1'b1;
      end
    end
  end

  // Hit data path and byte-lane merge
  lc3b_cacheline hit_line;
  lc3b_word      hit_word;
  lc3b_word      merged_word;

  always_comb begin
    hit_line    = data_q[idx][hit_way];
    hit_word    = hit_line[word_lsb +: WORD_W];
    merged_word = hit_word;
    if (bus.mem_byte_enable[0]) merged_word[7:0]  = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) merged_word[15:8] = bus.mem_wdata[15:8];
  end

  // FSM next-state and outputs
  logic hit_we;
  logic fill_we;
  logic plru_we;

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    hit_we         = 1'b0;
    fill_we        = 1'b0;
    plru_we        = 1'b0;
    bus.mem_resp   = 1'b0;
    bus.mem_rdata  = hit_word;
    bus.l2_read    = 1'b0;
    bus.l2_write   = 1'b0;
    bus.l2_address = '0;
    bus.l2_wdata   = '0;
    bus.eviction   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_one) begin
            bus.mem_resp = 1'b1;
            plru_we      = 1'b1;
            hit_we       = bus.mem_write;
          end else begin
            victim_d = victim_sel;
            if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FILL;
            end
          end
        end
      end

      WRITEBACK: begin
        bus.l2_write   = 1'b1;
        bus.eviction   = 1'b1;
        bus.l2_address = {tag_q[idx][victim_q], idx, {LC3B_OFFSET_BITS{1'b0}}};
        bus.l2_wdata   = data_q[idx][victim_q];
        if (bus.l2_resp) state_d = FILL;
      end

      FILL: begin
        bus.l2_read    = 1'b1;
        bus.l2_address = {tag_in, idx, {LC3B_OFFSET_BITS{1'b0}}};
        if (bus.l2_resp) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Status state: FSM, latched victim, valid/dirty/PLRU bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (plru_we) plru_q[idx] <= plru_next;
      if (hit_we) dirty_q[idx][hit_way] <= 1'b1;
      if (fill_we) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx][victim_q]  <= tag_in;
      data_q[idx][victim_q] <= bus.l2_rdata;
    end else if (hit_we) begin
      data_q[idx][hit_way][word_lsb +: WORD_W] <= merged_word;
    end
  end

endmodule

// File: tb/tb_l1_cache_nway.sv
// tb/tb_l1_cache_nway.sv - directed self-checking bench for l1_cache_nway (2-way and 4-way)
module tb_l1_cache_nway;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l1_cache_nway_if bus2 ();
  l1_cache_nway_if bus4 ();

  l1_cache_nway #(.WAYS(2), .SETS(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  l1_cache_nway #(.WAYS(4), .SETS(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  lc3b_cacheline l2_mem [4096];

  lc3b_word      last_rdata, last_wb_addr, last_fill_addr;
  lc3b_cacheline last_wb_data;
  int            last_cycles;
  bit            last_got, last_evict, both_seen;

  // CPU request on the 2-way cache with an immediate-response next level.
  task automatic cpu_access(input logic wr, input lc3b_word addr, input lc3b_word wdata,
                            input lc3b_mem_wmask be);
    last_got = 0; last_evict = 0; last_cycles = -1;
    last_wb_addr = 16'h0; last_fill_addr = 16'h0; last_rdata = 16'h0;
    bus2.mem_read = ~wr; bus2.mem_write = wr; bus2.mem_address = addr;
    bus2.mem_wdata = wdata; bus2.mem_byte_enable = be;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus2.l2_read && bus2.l2_write) both_seen = 1;
      if (bus2.mem_resp) begin
        last_got = 1; last_cycles = c; last_rdata = bus2.mem_rdata;
        break;
      end
      if (bus2.l2_write) begin
        last_evict   = last_evict | bus2.eviction;
        last_wb_addr = bus2.l2_address;
        last_wb_data = bus2.l2_wdata;
        l2_mem[bus2.l2_address[15:4]] = bus2.l2_wdata;
        bus2.l2_resp = 1'b1;
      end else if (bus2.l2_read) begin
        last_fill_addr = bus2.l2_address;
        bus2.l2_rdata  = l2_mem[bus2.l2_address[15:4]];
        bus2.l2_resp   = 1'b1;
      end
      @(negedge clk);
      bus2.l2_resp = 1'b0;
    end
    if (last_got) @(negedge clk);
    bus2.mem_read = 1'b0; bus2.mem_write = 1'b0;
  endtask

  // Read request on the 4-way cache.
  task automatic access4(input lc3b_word addr);
    last_got = 0; last_cycles = -1; last_fill_addr = 16'h0; last_rdata = 16'h0;
    bus4.mem_read = 1'b1; bus4.mem_address = addr;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus4.mem_resp) begin
        last_got = 1; last_cycles = c; last_rdata = bus4.mem_rdata;
        break;
      end
      if (bus4.l2_read) begin
        last_fill_addr = bus4.l2_address;
        bus4.l2_rdata  = l2_mem[bus4.l2_address[15:4]];
        bus4.l2_resp   = 1'b1;
      end
      @(negedge clk);
      bus4.l2_resp = 1'b0;
    end
    if (last_got) @(negedge clk);
    bus4.mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus2.mem_read = 1'b1; bus2.mem_address = 16'h1234;
    bus4.mem_read = 1'b1; bus4.mem_address = 16'h1234;
    @(negedge clk); #1;
    total++;
    if ({bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl2 got=%b want=0000",
               {bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction});
    end
    total++;
    if ({bus4.mem_resp, bus4.l2_read, bus4.l2_write, bus4.eviction} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl4 got=%b want=0000",
               {bus4.mem_resp, bus4.l2_read, bus4.l2_write, bus4.eviction});
    end
    bus2.mem_read = 1'b0; bus4.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction} !== 4'b0 ||
        bus2.l2_address !== 16'h0 || bus2.l2_wdata !== 128'h0) begin
      bad++;
      $display("FAIL idle_outputs ctrl=%b addr=%h want zeros",
               {bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction}, bus2.l2_address);
    end
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    cpu_access(1'b0, 16'h1234, 16'h0, 2'b00);
    total++;
    if (!last_got || last_rdata !== 16'h5A5A) begin
      bad++; $display("FAIL cold_rdata got=%h resp=%0d want=5a5a", last_rdata, last_got);
    end
    total++;
    if (last_fill_addr !== 16'h1230) begin
      bad++; $display("FAIL cold_fill_addr got=%h want=1230", last_fill_addr);
    end
    total++;
    if (last_cycles !== 2 || last_evict !== 1'b0) begin
      bad++; $display("FAIL cold_latency got=%0d evict=%0d want=2 evict=0", last_cycles, last_evict);
    end
    #1;
    total++;
    if (bus2.mem_resp !== 1'b0 || bus2.l2_read !== 1'b0) begin
      bad++; $display("FAIL resp_one_cycle resp=%b l2_read=%b want=0 0", bus2.mem_resp, bus2.l2_read);
    end
    @(negedge clk);
  endtask

  task automatic test_write_hit();
    cpu_access(1'b1, 16'h1234, 16'hABCD, 2'b01);
    total++;
    if (!last_got || last_cycles !== 0) begin
      bad++; $display("FAIL write_hit_same_cycle got=%0d want=0", last_cycles);
    end
    cpu_access(1'b0, 16'h1234, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 0 || last_rdata !== 16'h5ACD) begin
      bad++; $display("FAIL write_merge_lo got=%h cyc=%0d want=5acd cyc=0", last_rdata, last_cycles);
    end
    cpu_access(1'b1, 16'h1236, 16'h7788, 2'b10);
    cpu_access(1'b0, 16'h1236, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 0 || last_rdata !== 16'h7733) begin
      bad++; $display("FAIL write_merge_hi got=%h cyc=%0d want=7733 cyc=0", last_rdata, last_cycles);
    end
  endtask

  task automatic test_dirty_eviction();
    cpu_access(1'b0, 16'h1334, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 2 || last_evict !== 1'b0 || last_fill_addr !== 16'h1330) begin
      bad++; $display("FAIL second_way_fill cyc=%0d evict=%0d addr=%h want=2 0 1330",
                      last_cycles, last_evict, last_fill_addr);
    end
    cpu_access(1'b0, 16'h1434, 16'h0, 2'b00);
    total++;
    if (last_evict !== 1'b1) begin
      bad++; $display("FAIL eviction_flag got=%0d want=1", last_evict);
    end
    total++;
    if (last_wb_addr !== 16'h1230 || last_wb_data[47:32] !== 16'h5ACD) begin
      bad++; $display("FAIL writeback got addr=%h w2=%h want=1230 5acd",
                      last_wb_addr, last_wb_data[47:32]);
    end
    total++;
    if (last_fill_addr !== 16'h1430 || last_cycles !== 3 || last_rdata !== 16'h1432) begin
      bad++; $display("FAIL dirty_fill addr=%h cyc=%0d data=%h want=1430 3 1432",
                      last_fill_addr, last_cycles, last_rdata);
    end
    total++;
    if (both_seen !== 1'b0) begin
      bad++; $display("FAIL l2_rd_wr_overlap got=%0d want=0", both_seen);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    cpu_access(1'b0, 16'h1234, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 2 || last_rdata !== 16'h5ACD) begin
      bad++; $display("FAIL refill_from_wb cyc=%0d data=%h want=2 5acd", last_cycles, last_rdata);
    end
    cpu_access(1'b0, 16'h1234, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 0) begin
      bad++; $display("FAIL pre_reset_hit cyc=%0d want=0", last_cycles);
    end
    seen = 0;
    bus2.mem_read = 1'b1; bus2.mem_address = 16'h1534;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus2.l2_read) begin seen = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL midfill_l2_read got=0 want=1");
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus2.l2_read !== 1'b0 || bus2.mem_resp !== 1'b0) begin
      bad++; $display("FAIL reset_drops_read l2_read=%b resp=%b want=0 0", bus2.l2_read, bus2.mem_resp);
    end
    bus2.l2_resp = 1'b1; bus2.l2_rdata = '1;
    @(negedge clk);
    rst = 1'b0; bus2.mem_read = 1'b0;
    @(negedge clk);
    bus2.l2_resp = 1'b0;
    #1;
    total++;
    if ({bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction} !== 4'b0) begin
      bad++; $display("FAIL late_resp_ignored got=%b want=0000",
                      {bus2.mem_resp, bus2.l2_read, bus2.l2_write, bus2.eviction});
    end
    @(negedge clk);
    cpu_access(1'b0, 16'h1234, 16'h0, 2'b00);
    total++;
    if (last_cycles !== 2 || last_rdata !== 16'h5ACD) begin
      bad++; $display("FAIL post_reset_miss cyc=%0d data=%h want=2 5acd", last_cycles, last_rdata);
    end
  endtask

  task automatic test_plru_4way();
    lc3b_word fills [4];
    lc3b_word hits [4];
    fills = '{16'h0034, 16'h0134, 16'h0234, 16'h0334};
    hits  = '{16'h0034, 16'h0134, 16'h0334, 16'h0434};
    for (int i = 0; i < 4; i++) begin
      access4(fills[i]);
      total++;
      if (last_cycles !== 2) begin
        bad++; $display("FAIL plru_fill%0d cyc=%0d want=2", i, last_cycles);
      end
    end
    access4(16'h0034);
    total++;
    if (last_cycles !== 0) begin
      bad++; $display("FAIL plru_reread cyc=%0d want=0", last_cycles);
    end
    access4(16'h0434);
    total++;
    if (last_cycles !== 2 || last_fill_addr !== 16'h0430 || last_rdata !== 16'h0432) begin
      bad++; $display("FAIL plru_newline cyc=%0d addr=%h data=%h want=2 0430 0432",
                      last_cycles, last_fill_addr, last_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      access4(hits[i]);
      total++;
      if (last_cycles !== 0) begin
        bad++; $display("FAIL plru_kept%0d addr=%h cyc=%0d want=0", i, hits[i], last_cycles);
      end
    end
    access4(16'h0234);
    total++;
    if (last_cycles !== 2) begin
      bad++; $display("FAIL plru_victim_0234 cyc=%0d want=2", last_cycles);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      for (int w = 0; w < 8; w++) l2_mem[i][w*16 +: 16] = {i[11:0], w[3:0]};
    end
    l2_mem[12'h123][47:32] = 16'h5A5A;
    both_seen = 0;
    bus2.mem_read = 1'b0; bus2.mem_write = 1'b0; bus2.mem_address = 16'h0;
    bus2.mem_wdata = 16'h0; bus2.mem_byte_enable = 2'b00;
    bus2.l2_resp = 1'b0; bus2.l2_rdata = '0;
    bus4.mem_read = 1'b0; bus4.mem_write = 1'b0; bus4.mem_address = 16'h0;
    bus4.mem_wdata = 16'h0; bus4.mem_byte_enable = 2'b00;
    bus4.l2_resp = 1'b0; bus4.l2_rdata = '0;

    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_eviction();
    test_reset_mid_fill();
    test_plru_4way();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_cache_nway.md
L1_CACHE_NWAY -- requirements
Module: l1_cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity: power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 8, sets per way: power of two, 2..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports mem_read and mem_write, input, 1 bit each: CPU request strobes, held until mem_resp.
REQ-006 SHALL have ports mem_address and mem_wdata, input, lc3b_word each: CPU byte address and write data.
REQ-007 SHALL have port mem_byte_enable, input, lc3b_mem_wmask: byte lanes written on a CPU write.
REQ-008 SHALL have port mem_resp, output, 1 bit: request complete.
REQ-009 SHALL have port mem_rdata, output, lc3b_word: read data, valid while mem_resp is high.
REQ-010 SHALL have ports l2_read and l2_write, output, 1 bit each: next-level requests, held until l2_resp.
REQ-011 SHALL have port l2_address, output, lc3b_word: line-aligned address, bits [3:0] always zero.
REQ-012 SHALL have port l2_wdata, output, lc3b_cacheline: victim line during writeback.
REQ-013 SHALL have port l2_resp, input, 1 bit: next-level completion.
REQ-014 SHALL have port l2_rdata, input, lc3b_cacheline: fill data, sampled when l2_resp is high.
REQ-015 SHALL have port eviction, output, 1 bit: high for every cycle of a dirty-victim writeback.

Function
REQ-016 SHALL split the address as offset [3:0], index [3+log2(SETS):4], and tag (the remaining upper bits).
REQ-017 SHALL hold a tag, valid bit, dirty bit and 128-bit line per way per set, plus WAYS-1 tree-PLRU bits per set.
REQ-018 SHALL use the FSM states IDLE, WRITEBACK and FILL.
REQ-019 SHALL, in IDLE, treat a request as a hit when exactly one valid way's tag matches; mem_resp is then asserted combinationally in that same cycle.
REQ-020 SHALL, on a read hit, drive mem_rdata with word mem_address[3:1] of the hit line.
REQ-021 SHALL, on a write hit, merge mem_wdata into that word per mem_byte_enable and set the way's dirty bit at the clock edge.
REQ-022 SHALL, on every hit, update that set's PLRU bits so the tree points away from the hit way.
REQ-023 SHALL choose the victim as the lowest-index invalid way if one exists, otherwise the PLRU way.
REQ-024 SHALL, on a miss, go IDLE->WRITEBACK if the victim is valid and dirty, otherwise IDLE->FILL; mem_resp stays low throughout the miss.
REQ-025 SHALL, in WRITEBACK, drive l2_write=1, eviction=1, l2_address={victim tag, index, 4'h0} and l2_wdata=victim line, and go to FILL on l2_resp.
REQ-026 SHALL, in FILL, drive l2_read=1 and l2_address={tag, index, 4'h0}.
REQ-027 SHALL, on l2_resp in FILL, write l2_rdata, the tag and valid=1, dirty=0 into the victim way, then return to IDLE, where the request hits on the next cycle.
REQ-028 SHALL give a clean-miss latency of FILL cycles + 1 and a dirty-miss latency of WRITEBACK cycles + FILL cycles + 1.
REQ-029 SHALL never assert l2_read and l2_write in the same cycle.
REQ-030 SHALL ignore l2_resp while in IDLE.
REQ-031 SHALL drive all outputs other than mem_rdata to 0 while in IDLE with no request; mem_rdata is don't-care whenever mem_resp is low.
REQ-032 SHALL latch the victim way at the IDLE->miss transition and hold it until the return to IDLE.

Reset
REQ-033 SHALL, while rst is high, clear every valid bit, dirty bit and PLRU bit and force the state to IDLE, asynchronously.
REQ-034 SHALL drive mem_resp, l2_read, l2_write and eviction to 0 during reset; tag and data arrays are not reset.
REQ-035 SHALL, when reset is asserted mid-WRITEBACK or mid-FILL, drop the l2 request in the same cycle and discard any late l2_resp.

Structure
REQ-036 SHALL take lc3b_word, lc3b_cacheline and lc3b_mem_wmask from package lc3b_types, and SHALL add to that package the constants LC3B_OFFSET_BITS=4 and LC3B_LINE_WORDS=8.
REQ-037 SHALL implement the tree-PLRU update and victim encoding in a parametrised sub-module plru_tree (WAYS parameter; inputs: bits, hit way; outputs: next bits, victim).

Verification (WAYS=2, SETS=8 unless stated; the 0xNN34 addresses below all use index 3)
REQ-038 SHALL check a cold read: after reset, read 0x1234 -> l2_read with l2_address 0x1230; l2_rdata word2=0x5A5A -> after l2_resp, mem_resp for one cycle with mem_rdata=0x5A5A.
REQ-039 SHALL check a write hit: write 0x1234, wdata 0xABCD, mem_byte_enable 2'b01 -> same-cycle mem_resp, and a subsequent read returns 0x5ACD.
REQ-040 SHALL check a dirty eviction: read 0x1334, then read 0x1434 -> eviction=1, l2_write to 0x1230 with word2=0x5ACD, then l2_read to 0x1430.
REQ-041 SHALL check reset mid-FILL: rst pulsed while l2_read is high -> l2_read=0 immediately, and a later read of 0x1234 misses.
REQ-042 SHALL check PLRU with WAYS=4: fill 0x0034, 0x0134, 0x0234, 0x0334, re-read 0x0034, then read 0x0434 -> the victim is the way holding 0x0234.
